// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared types and round-robin helper for mem_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    localparam int ARB_MAX_N = 32;
    localparam int ID_W      = 5;

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
        logic            err;
    } rsp_t;

    // Returns the first set request at or after ptr (wrapping mod n), or -1.
    function automatic int rr_find(input logic [ARB_MAX_N-1:0] req,
                                   input int ptr, input int n);
        int idx;
        int win;
        win = -1;
        for (int k = ARB_MAX_N - 1; k >= 0; k--) begin
            if (k < n) begin
                idx = ptr + k;
                if (idx >= n) idx = idx - n;
                if (req[idx[ID_W-1:0]]) win = idx;
            end
        end
        return win;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Single-class round-robin arbiter with one-hot grant.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req,
    output logic [N_REQ-1:0]         grant,
    output logic [$clog2(N_REQ)-1:0] grant_idx,
    output logic                     any
);

    localparam int IDX_W = $clog2(N_REQ);

    logic [IDX_W-1:0]     r_ptr;
    logic [ARB_MAX_N-1:0] w_req_ext;
    int                   w_win;

    always_comb begin
        w_req_ext             = '0;
        w_req_ext[N_REQ-1:0]  = req;
        w_win                 = rr_find(w_req_ext, int'(r_ptr), N_REQ);
        any                   = (w_win >= 0);
        grant_idx             = any ? IDX_W'(w_win) : '0;
        grant                 = any ? (N_REQ'(1) << grant_idx) : '0;
    end

    // Winner drops to lowest priority for the next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (any) begin
            r_ptr <= (grant_idx == IDX_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Independent write/read round-robin arbitration in front of a
//               register memory with range filtering and a response stage.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter  int N_REQ    = 4,
    parameter  int MEM_SIZE = 6,
    parameter  int DATA_W   = 10,
    localparam int ADDR_W   = $clog2(MEM_SIZE)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ-1:0]        req_we,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    input  logic [N_REQ*DATA_W-1:0] req_wdata,
    output logic [N_REQ-1:0]        req_ready,
    output logic [N_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]       rsp_data,
    output logic                    rsp_err,
    output logic                    wr_err,
    output logic                    mem_write,
    output logic [ADDR_W-1:0]       mem_addr_w,
    output logic [DATA_W-1:0]       mem_data_in,
    output logic                    mem_read,
    output logic [ADDR_W-1:0]       mem_addr_r,
    input  logic [DATA_W-1:0]       mem_data_out
);

    localparam int IDX_W = $clog2(N_REQ);

    logic [N_REQ-1:0]  w_wr_req, w_rd_req, w_wr_grant, w_rd_grant;
    logic [IDX_W-1:0]  w_wr_idx, w_rd_idx;
    logic              w_wr_any, w_rd_any;
    logic [ADDR_W-1:0] w_wr_addr, w_rd_addr;
    logic [DATA_W-1:0] w_wr_data;
    logic              w_wr_in, w_rd_in;
    rsp_t              r_rsp;
    logic              r_wr_err;

    assign w_wr_req = req_valid & req_we;
    assign w_rd_req = req_valid & ~req_we;

    rr_arbiter #(.N_REQ(N_REQ)) u_wr_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (w_wr_req),
        .grant     (w_wr_grant),
        .grant_idx (w_wr_idx),
        .any       (w_wr_any)
    );

    rr_arbiter #(.N_REQ(N_REQ)) u_rd_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (w_rd_req),
        .grant     (w_rd_grant),
        .grant_idx (w_rd_idx),
        .any       (w_rd_any)
    );

    assign w_wr_addr = req_addr[w_wr_idx*ADDR_W +: ADDR_W];
    assign w_rd_addr = req_addr[w_rd_idx*ADDR_W +: ADDR_W];
    assign w_wr_data = req_wdata[w_wr_idx*DATA_W +: DATA_W];
    assign w_wr_in   = ({1'b0, w_wr_addr} < (ADDR_W + 1)'(MEM_SIZE));
    assign w_rd_in   = ({1'b0, w_rd_addr} < (ADDR_W + 1)'(MEM_SIZE));

    // Gating with rst_n keeps the combinational outputs quiet while in reset.
    assign req_ready   = (w_wr_grant | w_rd_grant) & {N_REQ{rst_n}};
    assign mem_write   = rst_n & w_wr_any & w_wr_in;
    assign mem_addr_w  = mem_write ? w_wr_addr : '0;
    assign mem_data_in = mem_write ? w_wr_data : '0;
    assign mem_read    = rst_n & w_rd_any & w_rd_in;
    assign mem_addr_r  = mem_read ? w_rd_addr : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp    <= '0;
            r_wr_err <= 1'b0;
        end else begin
            r_rsp.valid <= w_rd_any;
            r_rsp.id    <= ID_W'(w_rd_idx);
            r_rsp.err   <= ~w_rd_in;
            r_wr_err    <= w_wr_any & ~w_wr_in;
        end
    end

    // Memory output is unreset, so data is only passed through for a valid hit.
    assign rsp_valid = r_rsp.valid ? (N_REQ'(1) << r_rsp.id) : '0;
    assign rsp_data  = (r_rsp.valid & ~r_rsp.err) ? mem_data_out : '0;
    assign rsp_err   = r_rsp.valid & r_rsp.err;
    assign wr_err    = r_wr_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Self-checking bench for mem_arbiter with memory and scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int N  = 4;
    localparam int MS = 6;
    localparam int DW = 10;
    localparam int AW = 3;

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    req_valid, req_we, req_ready, rsp_valid;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [DW-1:0]   rsp_data, mem_data_in, mem_data_out;
    logic            rsp_err, wr_err, mem_write, mem_read;
    logic [AW-1:0]   mem_addr_w, mem_addr_r;

    mem_arbiter #(.N_REQ(N), .MEM_SIZE(MS), .DATA_W(DW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_ready    (req_ready),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .rsp_err      (rsp_err),
        .wr_err       (wr_err),
        .mem_write    (mem_write),
        .mem_addr_w   (mem_addr_w),
        .mem_data_in  (mem_data_in),
        .mem_read     (mem_read),
        .mem_addr_r   (mem_addr_r),
        .mem_data_out (mem_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Environment memory: one write port, registered read port.
    logic [DW-1:0] mem [0:7];
    always @(posedge clk) begin
        if (mem_write) mem[mem_addr_w] <= mem_data_in;
        if (mem_read)  mem_data_out    <= mem[mem_addr_r];
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    endtask

    // Reference round-robin pick.
    function automatic int ref_pick(input logic [N-1:0] req, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (req[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    typedef struct {
        logic [N-1:0]  onehot;
        logic [DW-1:0] data;
        logic          err;
    } exp_t;

    exp_t          sb_q[$];
    exp_t          e;
    logic [DW-1:0] shadow [0:MS-1];
    int            wp, rp, ww, rw;
    logic          exp_wr_err, w_in, r_in;
    logic [N-1:0]  exp_ready;
    logic [AW-1:0] wa, ra;
    logic [DW-1:0] wd;

    always @(negedge clk) begin
        if (!rst_n) begin
            sb_q.delete();
            wp = 0; rp = 0; exp_wr_err = 1'b0;
            check_eq("rst_req_ready", 32'(req_ready), 32'd0);
            check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
            check_eq("rst_rsp_data",  32'(rsp_data),  32'd0);
            check_eq("rst_errs",      32'({rsp_err, wr_err}), 32'd0);
            check_eq("rst_mem_ctl",   32'({mem_write, mem_read}), 32'd0);
            check_eq("rst_mem_bus",   32'({mem_addr_w, mem_addr_r, mem_data_in}), 32'd0);
        end else begin
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check_eq("rsp_valid", 32'(rsp_valid), 32'(e.onehot));
                check_eq("rsp_data",  32'(rsp_data),  32'(e.data));
                check_eq("rsp_err",   32'(rsp_err),   32'(e.err));
            end else begin
                check_eq("rsp_idle", 32'({rsp_valid, rsp_data, rsp_err}), 32'd0);
            end
            check_eq("wr_err", 32'(wr_err), 32'(exp_wr_err));

            ww = ref_pick(req_valid & req_we, wp);
            rw = ref_pick(req_valid & ~req_we, rp);
            exp_ready = '0;
            w_in = 1'b0; r_in = 1'b0; wa = '0; ra = '0; wd = '0;
            if (ww >= 0) begin
                exp_ready[ww] = 1'b1;
                wa   = req_addr[ww*AW +: AW];
                wd   = req_wdata[ww*DW +: DW];
                w_in = (int'(wa) < MS);
                wp   = (ww + 1) % N;
            end
            if (rw >= 0) begin
                exp_ready[rw] = 1'b1;
                ra   = req_addr[rw*AW +: AW];
                r_in = (int'(ra) < MS);
                rp   = (rw + 1) % N;
            end
            check_eq("req_ready",   32'(req_ready),   32'(exp_ready));
            check_eq("mem_write",   32'(mem_write),   32'(w_in));
            check_eq("mem_addr_w",  32'(mem_addr_w),  32'(w_in ? wa : '0));
            check_eq("mem_data_in", 32'(mem_data_in), 32'(w_in ? wd : '0));
            check_eq("mem_read",    32'(mem_read),    32'(r_in));
            check_eq("mem_addr_r",  32'(mem_addr_r),  32'(r_in ? ra : '0));
            if (rw >= 0) begin
                e.onehot = '0;
                e.onehot[rw] = 1'b1;
                e.data = r_in ? shadow[ra] : '0;
                e.err  = ~r_in;
                sb_q.push_back(e);
            end
            exp_wr_err = (ww >= 0) && !w_in;
            if (ww >= 0 && w_in) shadow[wa] = wd;
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic clr_all;
        req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    endtask

    task automatic set_req(input int i, input logic we, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
        req_valid[i] = 1'b1;
        req_we[i]    = we;
        req_addr[i*AW +: AW] = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) mem[i] = '0;
        for (int i = 0; i < MS; i++) shadow[i] = '0;
        mem_data_out = '0;
        rst_n = 1'b0;
        clr_all();

        // Reset with random request activity
        for (int c = 0; c < 3; c++) begin
            req_valid = N'($urandom);
            req_we    = N'($urandom);
            req_addr  = (N*AW)'($urandom);
            req_wdata = (N*DW)'({$urandom, $urandom});
            step();
        end
        clr_all();
        rst_n = 1'b1;
        step(); step();

        // Fairness: all four read continuously
        for (int i = 0; i < N; i++) set_req(i, 1'b0, AW'(i), '0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check_eq("fair_grant", 32'(req_ready), 32'(1 << (k % 4)));
            step();
        end
        clr_all();
        step();

        // Write then read back
        set_req(0, 1'b1, 3'd2, 10'h155);
        @(negedge clk);
        check_eq("wr_ready0", 32'(req_ready[0]), 32'd1);
        check_eq("wr_mem_write", 32'(mem_write), 32'd1);
        step();
        clr_all();
        set_req(1, 1'b0, 3'd2, '0);
        step();
        clr_all();
        @(negedge clk);
        check_eq("rd_rsp_valid", 32'(rsp_valid), 32'h2);
        check_eq("rd_rsp_data", 32'(rsp_data), 32'h155);
        step();

        // Same-cycle write/read hazard on address 3
        set_req(0, 1'b1, 3'd3, 10'h011);
        step();
        clr_all();
        set_req(0, 1'b1, 3'd3, 10'h0AA);
        set_req(2, 1'b0, 3'd3, '0);
        @(negedge clk);
        check_eq("hz_ready", 32'(req_ready), 32'h5);
        step();
        clr_all();
        @(negedge clk);
        check_eq("hz_old_data", 32'(rsp_data), 32'h011);
        step();
        set_req(2, 1'b0, 3'd3, '0);
        step();
        clr_all();
        @(negedge clk);
        check_eq("hz_new_data", 32'(rsp_data), 32'h0AA);
        step();

        // Out-of-range read and write
        set_req(3, 1'b0, 3'd7, '0);
        @(negedge clk);
        check_eq("oor_rd_ready", 32'(req_ready), 32'h8);
        check_eq("oor_rd_mem_read", 32'(mem_read), 32'd0);
        step();
        clr_all();
        @(negedge clk);
        check_eq("oor_rsp", 32'({rsp_valid, rsp_err}), 32'({4'b1000, 1'b1}));
        check_eq("oor_rsp_data", 32'(rsp_data), 32'd0);
        step();
        set_req(1, 1'b1, 3'd6, 10'h3FF);
        @(negedge clk);
        check_eq("oor_wr_ready", 32'(req_ready), 32'h2);
        check_eq("oor_wr_mem_write", 32'(mem_write), 32'd0);
        step();
        clr_all();
        @(negedge clk);
        check_eq("oor_wr_err", 32'(wr_err), 32'd1);
        step();

        // Reset mid-operation drops a pending response
        set_req(1, 1'b0, 3'd2, '0);
        step();
        clr_all();
        check_eq("pre_rst_rsp", 32'(rsp_valid), 32'h2);
        rst_n = 1'b0;
        #1;
        check_eq("rst_drop_rsp", 32'(rsp_valid), 32'd0);
        for (int i = 0; i < N; i++) set_req(i, 1'b0, AW'(i), '0);
        step();
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("post_rst_grant", 32'(req_ready), 32'h1);
        step();
        clr_all();
        step(); step(); step();

        check_eq("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
